// File: rtl/rr_grant_gen.sv
// rr_grant_gen: round-robin single-grant generator with a bounded hold time.
// The winner keeps its grant while it requests, up to MAX_HOLD cycles. Every
// release is followed by a one-cycle no-grant bubble before the next winner.
module rr_grant_gen #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_id,
  output logic                 busy,
  output logic                 timeout,
  output logic [15:0]          idle_cnt
);

  localparam int IW = $clog2(N);
  localparam int HW = $clog2(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state_q;
  logic [N-1:0]    gnt_q;
  logic [IW-1:0]   gnt_id_q;
  logic [IW-1:0]   ptr_q;
  logic [HW-1:0]   hold_cnt_q;
  logic            busy_q;
  logic            timeout_q;
  logic [15:0]     idle_cnt_q;

  logic            pick_found;
  logic [IW-1:0]   pick_id;
  logic [IW:0]     pick_sum;
  logic [IW:0]     rel_sum;
  logic [IW-1:0]   ptr_d;
  logic            held;
  logic            at_limit;

  // Round-robin search: first requester at or after ptr, wrapping N-1 -> 0.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    pick_sum   = '0;
    for (int i = 0; i < N; i++) begin
      pick_sum = {1'b0, ptr_q} + (IW+1)'(i);
      if (pick_sum >= (IW+1)'(N)) pick_sum = pick_sum - (IW+1)'(N);
      if (!pick_found && req[pick_sum[IW-1:0]]) begin
        pick_found = 1'b1;
        pick_id    = pick_sum[IW-1:0];
      end
    end
  end

  // Release bookkeeping: pointer moves to the requester after the released one.
  always_comb begin
    rel_sum = {1'b0, gnt_id_q} + (IW+1)'(1);
    if (rel_sum >= (IW+1)'(N)) rel_sum = rel_sum - (IW+1)'(N);
    ptr_d    = rel_sum[IW-1:0];
    held     = req[gnt_id_q];
    at_limit = (hold_cnt_q == HOLD_LAST);
  end

  // Two-state grant FSM; all outputs are registered and cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      gnt_id_q   <= '0;
      ptr_q      <= '0;
      hold_cnt_q <= '0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
      idle_cnt_q <= '0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pick_found) begin
            state_q    <= GRANT;
            gnt_q      <= N'(1) << pick_id;
            gnt_id_q   <= pick_id;
            busy_q     <= 1'b1;
            hold_cnt_q <= '0;
          end else if (idle_cnt_q != 16'hFFFF) begin
            idle_cnt_q <= idle_cnt_q + 16'd1;
          end
        end
        GRANT: begin
          // A drop wins over a coincident hold limit, so timeout only fires while held.
          if (!held || at_limit) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            gnt_id_q  <= '0;
            busy_q    <= 1'b0;
            ptr_q     <= ptr_d;
            timeout_q <= held;
          end else begin
            hold_cnt_q <= hold_cnt_q + HW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt      = gnt_q;
  assign gnt_id   = gnt_id_q;
  assign busy     = busy_q;
  assign timeout  = timeout_q;
  assign idle_cnt = idle_cnt_q;

endmodule

// File: tb/tb_rr_grant_gen.sv
// tb_rr_grant_gen: directed scoreboard bench for rr_grant_gen (N=4, MAX_HOLD=16).
// Each stimulus row drives req/rst_n just after a rising edge and queues the
// outputs expected for that same cycle; the monitor pops them on the falling edge.
module tb_rr_grant_gen;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;
  logic       timeout;
  logic [15:0] idle_cnt;

  typedef struct {
    logic [3:0] g;
    logic [1:0] id;
    logic       to;
    int         idle;   // -1 means idle_cnt not checked on this row
  } exp_t;

  exp_t exp_q[$];
  int   n_tot = 0;
  int   n_bad = 0;
  int   row   = 0;

  rr_grant_gen #(.N(4), .MAX_HOLD(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .gnt      (gnt),
    .gnt_id   (gnt_id),
    .busy     (busy),
    .timeout  (timeout),
    .idle_cnt (idle_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time (got running, want finished)");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [3:0] oh(input int id);
    logic [3:0] v;
    v = 4'b0001 << id;
    return v;
  endfunction

  // One scoreboarded cycle.
  task automatic step(input logic rn, input logic [3:0] r, input logic [3:0] eg,
                      input int eid, input logic eto, input int eidle);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = rn;
    req   = r;
    e.g = eg; e.id = 2'(eid); e.to = eto; e.idle = eidle;
    exp_q.push_back(e);
  endtask

  // One unscoreboarded cycle (invariants only).
  task automatic drive(input logic rn, input logic [3:0] r);
    @(posedge clk);
    #1;
    rst_n = rn;
    req   = r;
  endtask

  // Monitor: invariants every cycle, scoreboard entry whenever one is pending.
  always @(negedge clk) begin
    exp_t e;
    n_tot++;
    if (($countones(gnt) > 1) || (busy !== (|gnt)) ||
        ((gnt == 4'b0) && (gnt_id != 2'd0)) ||
        ((gnt != 4'b0) && (gnt !== oh(int'(gnt_id))))) begin
      n_bad++;
      $display("FAIL invariant t=%0t got gnt=%b gnt_id=%0d busy=%b want onehot0 gnt, busy=|gnt, id consistent",
               $time, gnt, gnt_id, busy);
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      row++;
      n_tot++;
      if ({gnt, gnt_id, timeout, busy} !== {e.g, e.id, e.to, |e.g}) begin
        n_bad++;
        $display("FAIL outputs row=%0d got gnt=%b id=%0d to=%b busy=%b want gnt=%b id=%0d to=%b busy=%b",
                 row, gnt, gnt_id, timeout, busy, e.g, e.id, e.to, |e.g);
      end
      if (e.idle >= 0) begin
        n_tot++;
        if (idle_cnt !== 16'(e.idle)) begin
          n_bad++;
          $display("FAIL idle_cnt row=%0d got %0d want %0d", row, idle_cnt, e.idle);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;

    // Reset state
    step(0, 4'b0000, 4'b0000, 0, 0, 0);
    step(0, 4'b0000, 4'b0000, 0, 0, 0);

    // Basic grant and release, other bits changing during a grant
    step(1, 4'b0110, 4'b0000, 0, 0, 0);
    step(1, 4'b0110, 4'b0010, 1, 0, 0);
    step(1, 4'b0100, 4'b0010, 1, 0, -1);
    step(1, 4'b0100, 4'b0000, 0, 0, 0);
    step(1, 4'b0100, 4'b0100, 2, 0, 0);
    step(1, 4'b0000, 4'b0100, 2, 0, -1);
    step(1, 4'b0000, 4'b0000, 0, 0, 0);
    step(1, 4'b0000, 4'b0000, 0, 0, 1);
    step(1, 4'b1000, 4'b0000, 0, 0, 2);
    step(1, 4'b1111, 4'b1000, 3, 0, 2);
    step(1, 4'b1010, 4'b1000, 3, 0, 2);
    step(1, 4'b1001, 4'b1000, 3, 0, 2);

    // Asynchronous reset mid-grant, then restart from ptr=0
    step(0, 4'b1001, 4'b0000, 0, 0, 0);
    step(1, 4'b1001, 4'b0000, 0, 0, 0);
    step(1, 4'b1001, 4'b0001, 0, 0, 0);
    step(1, 4'b0000, 4'b0001, 0, 0, -1);
    step(1, 4'b0000, 4'b0000, 0, 0, 0);

    // Rotation 0,1,2,3,0 with a bubble between grants
    step(0, 4'b0000, 4'b0000, 0, 0, 0);
    step(1, 4'b1111, 4'b0000, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      step(1, 4'b1111, oh(k % 4), k % 4, 0, -1);
      step(1, 4'b1111, oh(k % 4), k % 4, 0, -1);
      step(1, 4'b1111 & ~oh(k % 4), oh(k % 4), k % 4, 0, -1);
      step(1, 4'b1111, 4'b0000, 0, 0, -1);
    end

    // Timeout after 16 held cycles, regrant of the sole requester
    step(0, 4'b0001, 4'b0000, 0, 0, 0);
    step(1, 4'b0001, 4'b0000, 0, 0, 0);
    for (int k = 0; k < 16; k++) step(1, 4'b0001, 4'b0001, 0, 0, 0);
    step(1, 4'b0001, 4'b0000, 0, 1, 0);
    step(1, 4'b0001, 4'b0001, 0, 0, 0);
    // Drop coinciding with the hold limit: plain release, no timeout
    for (int k = 0; k < 14; k++) step(1, 4'b0001, 4'b0001, 0, 0, 0);
    step(1, 4'b0000, 4'b0001, 0, 0, 0);
    step(1, 4'b0000, 4'b0000, 0, 0, 0);
    step(1, 4'b0000, 4'b0000, 0, 0, 1);

    // Random requests with random resets (invariants only)
    for (int k = 0; k < 400; k++) begin
      drive(($urandom_range(0, 15) != 0), 4'($urandom));
    end

    // Idle counter saturation
    step(0, 4'b0000, 4'b0000, 0, 0, 0);
    step(1, 4'b0000, 4'b0000, 0, 0, 0);
    for (int k = 1; k <= 70000; k++) begin
      step(1, 4'b0000, 4'b0000, 0, 0, (k <= 65535) ? k : 65535);
    end

    repeat (2) @(negedge clk);
    n_tot++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain got pending=%0d want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule

// File: doc/rr_grant_gen.md
RR_GRANT_GEN -- requirements
Module: rr_grant_gen

Interface
REQ-001 Parameter N, default 4: number of requesters; legal range 2..16.
REQ-002 Parameter MAX_HOLD, default 16: maximum consecutive cycles one grant may be held; legal range 2..255.
REQ-003 The block SHALL have exactly one clock and one reset; the reset SHALL be asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 req  input  N  per-requester request level; any pattern is legal, including all-zero and all-one.
REQ-007 gnt  output  N  registered grant vector; at most one bit set; all-zero is a legal no-grant state.
REQ-008 gnt_id  output  $clog2(N)  index of the set gnt bit; 0 when gnt is zero.
REQ-009 busy  output  1  high exactly when gnt is nonzero.
REQ-010 timeout  output  1  one-cycle pulse when a grant is force-released at MAX_HOLD.
REQ-011 idle_cnt  output  16  saturating count of IDLE cycles with req all-zero.

Function
REQ-012 The FSM SHALL have exactly two states: IDLE and GRANT.
REQ-013 The block SHALL hold a round-robin pointer ptr of width $clog2(N).
REQ-014 In IDLE with req nonzero, the block SHALL select the first set req bit at or after ptr, searching upward and wrapping from N-1 to 0.
REQ-015 On the same clock edge, the block SHALL load gnt with that one-hot value, load gnt_id with its index, clear hold_cnt to 0, and enter GRANT.
REQ-016 Grant latency SHALL be exactly 1 cycle: gnt is visible after the first rising edge at which req is sampled nonzero in IDLE.
REQ-017 In IDLE with req all-zero, gnt SHALL stay 0, no error or flag SHALL be raised, and idle_cnt SHALL increment, saturating at 16'hFFFF with no wrap.
REQ-018 In GRANT, idle_cnt SHALL hold its value.
REQ-019 In GRANT, gnt and gnt_id SHALL remain stable, and hold_cnt SHALL increment each cycle, while req[gnt_id]=1 and hold_cnt < MAX_HOLD-1.
REQ-020 Changes on other req bits SHALL NOT affect an active grant.
REQ-021 Release by drop: when req[gnt_id]=0 is sampled in GRANT, at that edge the block SHALL clear gnt to 0, set ptr to (gnt_id+1) mod N, and enter IDLE.
REQ-022 Release by timeout: when req[gnt_id]=1 and hold_cnt = MAX_HOLD-1 are sampled, the block SHALL release exactly as in a drop release and SHALL pulse timeout high for exactly the following cycle.
REQ-023 After any release, at least one cycle SHALL pass with gnt all-zero before the next grant (a one-cycle bubble), so that no back-to-back grant switches occur.
REQ-024 If req[gnt_id] drops and hold_cnt = MAX_HOLD-1 on the same cycle, the block SHALL treat it as a drop release with no timeout pulse.
REQ-025 A requester released by timeout that still asserts req SHALL be re-eligible only in round-robin order after ptr.
REQ-026 $countones(gnt) SHALL be ≤ 1 in every cycle, including during reset and immediately after it.
REQ-027 gnt_id SHALL be 0 whenever gnt = 0.
REQ-028 busy SHALL equal |gnt.
REQ-029 hold_cnt SHALL be an internal counter of width $clog2(MAX_HOLD).

Reset
REQ-030 While rst_n=0, the block SHALL immediately drive state=IDLE, gnt=0, gnt_id=0, busy=0, timeout=0, ptr=0, hold_cnt=0, idle_cnt=0, with no wait for a clock edge.
REQ-031 Reset asserted during GRANT SHALL drop gnt asynchronously and SHALL NOT produce a timeout pulse.
REQ-032 After rst_n deasserts, the first grant decision SHALL occur at the first rising edge that samples rst_n=1.

Verification
REQ-033 Basic grant and release: with N=4, hold req=4'b0110 → gnt=4'b0010 and gnt_id=1 one cycle later; drop req[1] → one cycle with gnt=0, then gnt=4'b0100 with gnt_id=2.
REQ-034 Rotation: hold req=4'b1111, with each winner dropping after 3 cycles → grant order 0,1,2,3,0, with exactly one zero-gnt bubble between consecutive grants.
REQ-035 Timeout: MAX_HOLD=16, hold req=4'b0001 → gnt=4'b0001 for exactly 16 cycles, then timeout=1 for 1 cycle with gnt=0, then gnt=4'b0001 again (sole requester).
REQ-036 Idle saturation: hold req=0 for 70000 cycles → idle_cnt=16'hFFFF, gnt=0 throughout, no other output toggles.
REQ-037 Reset mid-grant: assert rst_n=0 mid-cycle while gnt=4'b1000 → gnt=0 and ptr=0 before the next edge; after release with req=4'b1001 → gnt=4'b0001.
REQ-038 Invariants: under random req with random reset, checkers confirm $countones(gnt)≤1, busy=|gnt, and gnt_id=0 whenever gnt=0 on every cycle.
